// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path.
// States, opcodes and the mux/ALU select codes driven by the sequencer.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR_LINK,
        S_LUI,
        S_AUIPC,
        S_ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_AUIPC  = 7'd23;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_JAL    = 7'd111;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_SLL   = 3'd5;
    localparam logic [2:0] ALU_SRL   = 3'd6;
    localparam logic [2:0] ALU_PASSB = 3'd7;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_B = 3'd1;
    localparam logic [2:0] IMM_U = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_S = 3'd4;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational instruction-field decoder: R/I-type ALU operation
// and a legality flag covering every supported encoding.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
        case (op)
            OP_R: begin
                case (funct3)
                    3'd0: begin
                        legal    = 1'b1;
                        alu_ctrl = funct7_5 ? ALU_SUB : ALU_ADD;
                    end
                    3'd6: begin
                        legal    = !funct7_5;
                        alu_ctrl = ALU_OR;
                    end
                    3'd7: begin
                        legal    = !funct7_5;
                        alu_ctrl = ALU_AND;
                    end
                    default: ;
                endcase
            end
            OP_IMM: begin
                case (funct3)
                    3'd0: begin
                        legal    = 1'b1;
                        alu_ctrl = ALU_ADD;
                    end
                    3'd1: begin
                        legal    = 1'b1;
                        alu_ctrl = ALU_SLL;
                    end
                    3'd4: begin
                        legal    = 1'b1;
                        alu_ctrl = ALU_XOR;
                    end
                    3'd5: begin
                        legal    = 1'b1;
                        alu_ctrl = ALU_SRL;
                    end
                    3'd7: begin
                        legal    = 1'b1;
                        alu_ctrl = ALU_AND;
                    end
                    default: ;
                endcase
            end
            OP_BRANCH: legal = (funct3 == 3'd0) || (funct3 == 3'd1);
            OP_JALR:   legal = (funct3 == 3'd0);
            OP_LOAD, OP_STORE, OP_JAL,
            OP_LUI, OP_AUIPC: legal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: one state per cycle, shared ALU and memory,
// sticky illegal-encoding flag and retired-instruction counter.
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7_5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       imm_src,
    output logic [2:0]       alu_ctrl,
    output logic             retire,
    output logic [CNT_W-1:0] retired_count,
    output logic             illegal
);

    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic illegal_q, illegal_d;

    logic [2:0] dec_alu;
    logic       dec_legal;

    logic       c_mem_req, c_mem_write, c_adr_src;
    logic       c_ir_write, c_pc_write, c_reg_write;
    logic [1:0] c_result_src, c_src_a, c_src_b;
    logic [2:0] c_imm_src, c_alu_ctrl;
    logic       c_retire;

    alu_decoder u_alu_dec (
        .op       (op),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_ctrl (dec_alu),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        c_mem_req    = 1'b0;
        c_mem_write  = 1'b0;
        c_adr_src    = 1'b0;
        c_ir_write   = 1'b0;
        c_pc_write   = 1'b0;
        c_reg_write  = 1'b0;
        c_result_src = RES_ALUOUT;
        c_src_a      = SRCA_PC;
        c_src_b      = SRCB_RS2;
        c_imm_src    = IMM_I;
        c_alu_ctrl   = ALU_ADD;
        c_retire     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                c_mem_req = 1'b1;
                if (mem_ready) begin
                    c_ir_write   = 1'b1;
                    c_pc_write   = 1'b1;
                    c_src_b      = SRCB_FOUR;
                    c_result_src = RES_ALU;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch/JAL target lands in ALUOut
                c_src_a   = SRCA_OLDPC;
                c_src_b   = SRCB_IMM;
                c_imm_src = (op == OP_JAL) ? IMM_J : IMM_B;
                if (!dec_legal)
                    state_d = S_ILLEGAL;
                else if (op == OP_LOAD || op == OP_STORE)
                    state_d = S_MEMADR;
                else if (op == OP_R)
                    state_d = S_EXEC_R;
                else if (op == OP_IMM)
                    state_d = S_EXEC_I;
                else if (op == OP_BRANCH)
                    state_d = S_BRANCH;
                else if (op == OP_JAL)
                    state_d = S_JAL;
                else if (op == OP_JALR)
                    state_d = S_JALR;
                else if (op == OP_LUI)
                    state_d = S_LUI;
                else if (op == OP_AUIPC)
                    state_d = S_AUIPC;
                else
                    state_d = S_ILLEGAL;
            end
            S_MEMADR: begin
                c_src_a   = SRCA_RS1;
                c_src_b   = SRCB_IMM;
                c_imm_src = (op == OP_LOAD) ? IMM_I : IMM_S;
                state_d   = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                c_mem_req = 1'b1;
                c_adr_src = 1'b1;
                if (mem_ready)
                    state_d = S_MEMWB;
            end
            S_MEMWB: begin
                c_result_src = RES_MEM;
                c_reg_write  = 1'b1;
                c_retire     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                c_mem_req   = 1'b1;
                c_mem_write = 1'b1;
                c_adr_src   = 1'b1;
                if (mem_ready) begin
                    c_retire = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXEC_R: begin
                c_src_a    = SRCA_RS1;
                c_src_b    = SRCB_RS2;
                c_alu_ctrl = dec_alu;
                state_d    = S_ALUWB;
            end
            S_EXEC_I: begin
                c_src_a    = SRCA_RS1;
                c_src_b    = SRCB_IMM;
                c_alu_ctrl = dec_alu;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                c_reg_write = 1'b1;
                c_retire    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                c_src_a    = SRCA_RS1;
                c_src_b    = SRCB_RS2;
                c_alu_ctrl = ALU_SUB;
                c_pc_write = (funct3 == 3'd0) ? zero : !zero;
                c_retire   = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL, S_JALR_LINK: begin
                // PC takes ALUOut target while ALU forms OldPC+4 link
                c_src_a    = SRCA_OLDPC;
                c_src_b    = SRCB_FOUR;
                c_pc_write = 1'b1;
                state_d    = S_ALUWB;
            end
            S_JALR: begin
                c_src_a = SRCA_RS1;
                c_src_b = SRCB_IMM;
                state_d = S_JALR_LINK;
            end
            S_LUI: begin
                c_src_b    = SRCB_IMM;
                c_imm_src  = IMM_U;
                c_alu_ctrl = ALU_PASSB;
                state_d    = S_ALUWB;
            end
            S_AUIPC: begin
                c_src_a   = SRCA_OLDPC;
                c_src_b   = SRCB_IMM;
                c_imm_src = IMM_U;
                state_d   = S_ALUWB;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, c_retire};
        illegal_d = illegal_q | (state_d == S_ILLEGAL);
    end

    // Reset held low suppresses every strobe, even though state is FETCH
    assign mem_req       = rst_n & c_mem_req;
    assign mem_write     = rst_n & c_mem_write;
    assign adr_src       = rst_n & c_adr_src;
    assign ir_write      = rst_n & c_ir_write;
    assign pc_write      = rst_n & c_pc_write;
    assign reg_write     = rst_n & c_reg_write;
    assign result_src    = rst_n ? c_result_src : 2'd0;
    assign alu_src_a     = rst_n ? c_src_a : 2'd0;
    assign alu_src_b     = rst_n ? c_src_b : 2'd0;
    assign imm_src       = rst_n ? c_imm_src : 3'd0;
    assign alu_ctrl      = rst_n ? c_alu_ctrl : 3'd0;
    assign retire        = rst_n & c_retire;
    assign retired_count = cnt_q;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a per-cycle scoreboard.
module tb_multicycle_control;

    typedef struct packed {
        logic        mem_req;
        logic        mem_write;
        logic        adr_src;
        logic        ir_write;
        logic        pc_write;
        logic        reg_write;
        logic [1:0]  result_src;
        logic [1:0]  src_a;
        logic [1:0]  src_b;
        logic [2:0]  imm_src;
        logic [2:0]  alu_ctrl;
        logic        retire;
        logic        illegal;
        logic [31:0] count;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7_5 = 1'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write;
    logic        reg_write, retire, illegal;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [2:0]  imm_src, alu_ctrl;
    logic [31:0] retired_count;

    ctl_t  q[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    exp_cnt = 0;
    bit    exp_ill = 1'b0;
    string tname = "reset";

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
        .retire(retire), .retired_count(retired_count), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic ctl_t v(bit mr, bit mw, bit as, bit irw, bit pcw,
                               bit rw, bit [1:0] rs, bit [1:0] a,
                               bit [1:0] b, bit [2:0] imm, bit [2:0] alu,
                               bit ret);
        ctl_t c;
        c = '{mr, mw, as, irw, pcw, rw, rs, a, b, imm, alu, ret, 1'b0, 32'd0};
        return c;
    endfunction

    task automatic cyc(input ctl_t e);
        e.illegal = exp_ill;
        e.count   = exp_cnt;
        q.push_back(e);
        if (e.retire) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        ctl_t got, exp;
        if (q.size() > 0) begin
            exp = q.pop_front();
            got = '{mem_req, mem_write, adr_src, ir_write, pc_write,
                    reg_write, result_src, alu_src_a, alu_src_b, imm_src,
                    alu_ctrl, retire, illegal, retired_count};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s t=%0t: got %h required %h",
                         tname, $time, got, exp);
            end
        end
    end

    // Hand-derived per-state control vectors
    ctl_t Z, F_WAIT, F_GO, DEC_B, DEC_J, EXI, EXR_SUB, ALUWB;
    ctl_t MADR_L, MADR_S, MRD, MWB, MWR, BR_T, BR_N, JLINK, JALR_A, LUI_C;

    task automatic fetch_decode(input bit jal);
        mem_ready = 1'b1;
        cyc(F_GO);
        cyc(jal ? DEC_J : DEC_B);
    endtask

    initial begin
        Z       = v(0,0,0,0,0,0, 0,0,0, 0,0, 0);
        F_WAIT  = v(1,0,0,0,0,0, 0,0,0, 0,0, 0);
        F_GO    = v(1,0,0,1,1,0, 2,0,2, 0,0, 0);
        DEC_B   = v(0,0,0,0,0,0, 0,1,1, 1,0, 0);
        DEC_J   = v(0,0,0,0,0,0, 0,1,1, 3,0, 0);
        EXI     = v(0,0,0,0,0,0, 0,2,1, 0,0, 0);
        EXR_SUB = v(0,0,0,0,0,0, 0,2,0, 0,1, 0);
        ALUWB   = v(0,0,0,0,0,1, 0,0,0, 0,0, 1);
        MADR_L  = v(0,0,0,0,0,0, 0,2,1, 0,0, 0);
        MADR_S  = v(0,0,0,0,0,0, 0,2,1, 4,0, 0);
        MRD     = v(1,0,1,0,0,0, 0,0,0, 0,0, 0);
        MWB     = v(0,0,0,0,0,1, 1,0,0, 0,0, 1);
        MWR     = v(1,1,1,0,0,0, 0,0,0, 0,0, 0);
        BR_T    = v(0,0,0,0,1,0, 0,2,0, 0,1, 1);
        BR_N    = v(0,0,0,0,0,0, 0,2,0, 0,1, 1);
        JLINK   = v(0,0,0,0,1,0, 0,1,2, 0,0, 0);
        JALR_A  = v(0,0,0,0,0,0, 0,2,1, 0,0, 0);
        LUI_C   = v(0,0,0,0,0,0, 0,0,1, 2,7, 0);

        fork
            begin
                #200000;
                $display("FAIL watchdog: time limit reached");
                $fatal(1, "timeout");
            end
        join_none

        @(posedge clk); #1;
        mem_ready = 1'b1;
        cyc(Z);
        cyc(Z);
        rst_n = 1'b1;

        tname = "addi";
        op = 7'd19; funct3 = 3'd0; funct7_5 = 1'b0;
        fetch_decode(0);
        cyc(EXI);
        cyc(ALUWB);

        tname = "lw";
        op = 7'd3; funct3 = 3'd2;
        mem_ready = 1'b0;
        repeat (3) cyc(F_WAIT);
        fetch_decode(0);
        mem_ready = 1'b0;
        cyc(MADR_L);
        repeat (3) cyc(MRD);
        mem_ready = 1'b1;
        cyc(MRD);
        cyc(MWB);

        tname = "beq";
        op = 7'd99; funct3 = 3'd0; zero = 1'b1;
        fetch_decode(0);
        cyc(BR_T);
        tname = "bne";
        funct3 = 3'd1;
        fetch_decode(0);
        cyc(BR_N);
        zero = 1'b0;

        tname = "jalr";
        op = 7'd103; funct3 = 3'd0;
        fetch_decode(0);
        cyc(JALR_A);
        cyc(JLINK);
        cyc(ALUWB);

        tname = "sub";
        op = 7'd51; funct3 = 3'd0; funct7_5 = 1'b1;
        fetch_decode(0);
        cyc(EXR_SUB);
        cyc(ALUWB);
        funct7_5 = 1'b0;

        tname = "jal";
        op = 7'd111; funct3 = 3'd5;
        fetch_decode(1);
        cyc(JLINK);
        cyc(ALUWB);

        tname = "lui";
        op = 7'd55; funct3 = 3'd0;
        fetch_decode(0);
        cyc(LUI_C);
        cyc(ALUWB);

        tname = "illegal";
        op = 7'h7F;
        fetch_decode(0);
        exp_ill = 1'b1;
        repeat (10) cyc(Z);

        tname = "illegal_reset";
        rst_n = 1'b0;
        exp_ill = 1'b0;
        exp_cnt = 0;
        cyc(Z);
        rst_n = 1'b1;
        op = 7'd35; funct3 = 3'd2;
        tname = "sw_reset";
        fetch_decode(0);
        mem_ready = 1'b0;
        cyc(MADR_S);
        cyc(MWR);
        rst_n = 1'b0;
        exp_cnt = 0;
        cyc(Z);
        cyc(Z);
        rst_n = 1'b1;
        cyc(F_WAIT);
        cyc(F_WAIT);

        @(posedge clk); #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the RV32I-subset core: one shared ALU and one unified instruction/data memory, reused across the cycles of each instruction.
- Replaces the single-cycle decoder.
- Drives IR/PC write enables, memory request handshake, ALU operand muxes, immediate type and ALU operation, one state per cycle.
- Flags unsupported encodings and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  7  instruction[6:0] from IR.
- funct3  in  3  instruction[14:12] from IR.
- funct7_5  in  1  instruction[30] from IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  access is a store (valid with mem_req).
- adr_src  out  1  memory address: 0 PC, 1 ALUOut.
- ir_write  out  1  load IR and OldPC.
- pc_write  out  1  load PC from result bus.
- reg_write  out  1  register file write.
- result_src  out  2  result bus: 0 ALUOut, 1 mem data, 2 ALU result.
- alu_src_a  out  2  0 PC, 1 OldPC, 2 rs1.
- alu_src_b  out  2  0 rs2, 1 imm, 2 const 4.
- imm_src  out  3  I=0, B=1, U=2, J=3, S=4.
- alu_ctrl  out  3  add=0, sub=1, and=2, or=3, xor=4, sll=5, srl=6, passB=7.
- retire  out  1  one-cycle pulse, instruction complete.
- retired_count  out  CNT_W  retired instructions.
- illegal  out  1  sticky, unsupported encoding seen.

Behaviour:
- Reset (rst_n low, async): state=FETCH, retired_count=0, illegal=0; all outputs forced 0 while rst_n low; FETCH outputs appear on the first cycle after release.
- Outputs decode combinationally from state (and IR fields); pc_write in BRANCH also uses zero. Any output not listed for a state is 0 (alu_ctrl 0, imm_src 0).
- FETCH: mem_req=1, adr_src=0. Hold until mem_ready; on the mem_ready cycle (zero-wait allowed): ir_write=1, pc_write=1, a=0, b=2, add, result_src=2 -> DECODE.
- DECODE: a=1, b=1, imm_src=B, add (branch/JAL target into ALUOut; for JAL drive imm_src=J). Legal set:
  - op 3 / 35 -> MEMADR
  - op 51 with f3/f7_5 in {0/0, 0/1, 6/0, 7/0} -> EXEC_R
  - op 19 with f3 in {0,1,4,5,7} -> EXEC_I
  - op 99 with f3 in {0,1} -> BRANCH
  - op 111 -> JAL; op 103 (f3=0) -> JALR
  - op 55 -> LUI; op 23 -> AUIPC
  - anything else -> ILLEGAL
- MEMADR: a=2, b=1, add, imm_src I (load) or S (store). -> MEMREAD if op=3, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1; wait mem_ready -> MEMWB.
- MEMWB: result_src=1, reg_write=1, retire -> FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1; on mem_ready: retire -> FETCH.
- EXEC_R: a=2, b=0, alu_ctrl: add/sub/or/and from f3, f7_5 -> ALUWB.
- EXEC_I: a=2, b=1, imm I, alu_ctrl: f3 0 add, 1 sll, 4 xor, 5 srl, 7 and -> ALUWB.
- ALUWB: result_src=0, reg_write=1, retire -> FETCH.
- BRANCH: a=2, b=0, sub, result_src=0; pc_write = zero (f3=0) or !zero (f3=1); retire -> FETCH.
- JAL: a=1, b=2, add, result_src=0, pc_write=1 -> ALUWB (writes OldPC+4).
- JALR: a=2, b=1, imm I, add -> JALR_LINK.
- JALR_LINK: a=1, b=2, add, result_src=0, pc_write=1 -> ALUWB.
- LUI: b=1, imm U, passB -> ALUWB.
- AUIPC: a=1, b=1, imm U, add -> ALUWB.
- ILLEGAL: all control outputs 0, illegal=1 (registered, sticky). Terminal until reset.
- mem_ready is ignored outside FETCH/MEMREAD/MEMWRITE. mem_req stays high until mem_ready, with no glitch between wait cycles.
- retired_count increments on every retire, wraps to 0.
- Reset mid-instruction: immediate return to FETCH; no partial writes after reset assertion.

Decomposition:
- Shared package riscv_ctrl_pkg:
  - state enum
  - opcode constants (OP_LOAD=3, OP_IMM=19, OP_AUIPC=23, OP_STORE=35, OP_R=51, OP_LUI=55, OP_BRANCH=99, OP_JALR=103, OP_JAL=111)
  - alu_ctrl, imm_src, result_src and src-mux encodings
- One sub-module: alu_decoder (combinational; op/funct3/funct7_5 -> alu_ctrl plus legal flag), used by DECODE and EXEC states.

Test Plan:
- addi x1,x0,5 (op19 f3=0), mem_ready always 1 -> FETCH, DECODE, EXEC_I, ALUWB; 4 cycles; retire pulse on cycle 4; retired_count=1.
- lw with mem_ready delayed 3 cycles in FETCH and MEMREAD -> mem_req held high through waits; ir_write only on ready cycle; reg_write with result_src=1 in MEMWB.
- beq with zero=1, then bne with zero=1 -> pc_write=1 in BRANCH for beq; pc_write=0 for bne; both retire.
- jalr -> JALR, JALR_LINK (pc_write=1, a=1, b=2), ALUWB reg_write=1; total 5 cycles.
- op=0x7F in DECODE -> ILLEGAL; illegal=1 sticky, mem_req stays 0 for 10 cycles; rst_n low clears it, FETCH resumes.
- rst_n asserted in MEMWRITE with mem_ready pending -> outputs 0 immediately; after release FETCH, retired_count=0, no mem_write.
